// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave in front of the NPC SRAM bridge: each accepted AR or AW+W pair
// becomes a single-cycle bridge pulse, followed by an optionally delayed R/B response.
module axi_lite_sram_slave #(
  parameter int unsigned R_EXTRA_DELAY = 0,
  parameter int unsigned W_EXTRA_DELAY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic        sram_read,
  output logic [31:0] sram_r_addr,
  input  logic [31:0] sram_r_data,
  output logic        sram_write,
  output logic [31:0] sram_w_addr,
  output logic [31:0] sram_w_data,
  output logic [3:0]  sram_w_strb
);

  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DELAY, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ISSUE, WR_DELAY, WR_RESP} wr_state_t;

  localparam logic [3:0] R_DLY = 4'(R_EXTRA_DELAY);
  localparam logic [3:0] W_DLY = 4'(W_EXTRA_DELAY);

  rd_state_t   rd_state_reg, rd_state_next;
  logic [3:0]  rd_cnt_reg, rd_cnt_next;
  logic [29:0] rd_addr_reg;
  logic        ar_hs;

  wr_state_t   wr_state_reg, wr_state_next;
  logic [3:0]  wr_cnt_reg, wr_cnt_next;
  logic [29:0] aw_addr_reg;
  logic [31:0] w_data_reg;
  logic [3:0]  w_strb_reg;
  logic        aw_got_reg, aw_got_next;
  logic        w_got_reg, w_got_next;
  logic        aw_hs, w_hs;

  logic        norm_ok;
  logic [1:0]  norm_off;
  logic [3:0]  norm_strb;

  // Byte-offset bits of the AXI addresses carry no information for a word-wide bridge.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, s_araddr[1:0], s_awaddr[1:0]};

  // Handshakes are derived from state, not from the ready outputs, to keep the
  // next-state logic free of combinational loops.
  assign ar_hs = s_arvalid && (rd_state_reg == RD_IDLE);
  assign aw_hs = s_awvalid && (wr_state_reg == WR_IDLE) && !aw_got_reg;
  assign w_hs  = s_wvalid  && (wr_state_reg == WR_IDLE) && !w_got_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_state_reg <= RD_IDLE;
      rd_cnt_reg   <= 4'd0;
      rd_addr_reg  <= 30'd0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_cnt_reg   <= rd_cnt_next;
      if (ar_hs) rd_addr_reg <= s_araddr[31:2];
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_cnt_next   = rd_cnt_reg;
    s_arready     = 1'b0;
    sram_read     = 1'b0;
    sram_r_addr   = 32'd0;
    s_rvalid      = 1'b0;
    s_rdata       = 32'd0;
    s_rresp       = 2'b00;
    case (rd_state_reg)
      RD_IDLE: if (ar_hs) rd_state_next = RD_ISSUE;
      RD_ISSUE: begin
        if (R_DLY != 4'd0) begin
          rd_state_next = RD_DELAY;
          rd_cnt_next   = R_DLY;
        end else begin
          rd_state_next = RD_RESP;
        end
      end
      RD_DELAY: begin
        if (rd_cnt_reg <= 4'd1) rd_state_next = RD_RESP;
        else rd_cnt_next = rd_cnt_reg - 4'd1;
      end
      RD_RESP: if (s_rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
    if (reset) begin
      case (rd_state_reg)
        RD_IDLE:  s_arready = 1'b1;
        RD_ISSUE: begin
          sram_read   = 1'b1;
          sram_r_addr = {rd_addr_reg, 2'b00};
        end
        RD_RESP: begin
          s_rvalid = 1'b1;
          s_rdata  = sram_r_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_state_reg <= WR_IDLE;
      wr_cnt_reg   <= 4'd0;
      aw_got_reg   <= 1'b0;
      w_got_reg    <= 1'b0;
      aw_addr_reg  <= 30'd0;
      w_data_reg   <= 32'd0;
      w_strb_reg   <= 4'd0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_cnt_reg   <= wr_cnt_next;
      aw_got_reg   <= aw_got_next;
      w_got_reg    <= w_got_next;
      if (aw_hs) aw_addr_reg <= s_awaddr[31:2];
      if (w_hs) begin
        w_data_reg <= s_wdata;
        w_strb_reg <= s_wstrb;
      end
    end
  end

  // Lane-positioned strobe -> low-aligned bridge strobe plus byte offset.
  always_comb begin
    norm_ok   = 1'b1;
    norm_off  = 2'd0;
    norm_strb = 4'b0000;
    case (w_strb_reg)
      4'b0001: norm_strb = 4'b0001;
      4'b0010: begin norm_off = 2'd1; norm_strb = 4'b0001; end
      4'b0100: begin norm_off = 2'd2; norm_strb = 4'b0001; end
      4'b1000: begin norm_off = 2'd3; norm_strb = 4'b0001; end
      4'b0011: norm_strb = 4'b0011;
      4'b1100: begin norm_off = 2'd2; norm_strb = 4'b0011; end
      4'b1111: norm_strb = 4'b1111;
      default: norm_ok = 1'b0;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_cnt_next   = wr_cnt_reg;
    aw_got_next   = aw_got_reg;
    w_got_next    = w_got_reg;
    s_awready     = 1'b0;
    s_wready      = 1'b0;
    sram_write    = 1'b0;
    sram_w_addr   = 32'd0;
    sram_w_data   = 32'd0;
    sram_w_strb   = 4'd0;
    s_bvalid      = 1'b0;
    s_bresp       = 2'b00;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_hs) aw_got_next = 1'b1;
        if (w_hs)  w_got_next  = 1'b1;
        if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs)) wr_state_next = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (W_DLY != 4'd0) begin
          wr_state_next = WR_DELAY;
          wr_cnt_next   = W_DLY;
        end else begin
          wr_state_next = WR_RESP;
        end
      end
      WR_DELAY: begin
        if (wr_cnt_reg <= 4'd1) wr_state_next = WR_RESP;
        else wr_cnt_next = wr_cnt_reg - 4'd1;
      end
      WR_RESP: begin
        if (s_bready) begin
          wr_state_next = WR_IDLE;
          aw_got_next   = 1'b0;
          w_got_next    = 1'b0;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
    if (reset) begin
      case (wr_state_reg)
        WR_IDLE: begin
          s_awready = !aw_got_reg;
          s_wready  = !w_got_reg;
        end
        WR_ISSUE: begin
          if (norm_ok) begin
            sram_write  = 1'b1;
            sram_w_addr = {aw_addr_reg, norm_off};
            sram_w_data = w_data_reg >> {norm_off, 3'b000};
            sram_w_strb = norm_strb;
          end
        end
        WR_RESP: begin
          s_bvalid = 1'b1;
          s_bresp  = norm_ok ? 2'b00 : 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite slave that sits directly upstream of the DPI SRAM bridge in the NPC memory path.
- Accepts AR/R and AW/W/B transactions from the LSU/IFU interconnect.
- Converts each accepted transaction into single-cycle `read` / `write` pulses on the bridge port set.
- Normalises AXI lane-positioned write strobes into the bridge's low-aligned 1/2/4-byte form.

Parameters:
R_EXTRA_DELAY, 0, extra wait cycles between bridge read pulse and rvalid (latency modelling, 0..15)
W_EXTRA_DELAY, 0, extra wait cycles between bridge write pulse and bvalid (0..15)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (reset==0 resets)
s_araddr  in  32  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response, always 2'b00
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_awaddr  in  32  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data, lane-positioned
s_wstrb  in  4  write byte strobes, lane-positioned
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
sram_read  out  1  bridge read pulse
sram_r_addr  out  32  bridge read address
sram_r_data  in  32  bridge read data (valid the cycle after sram_read; held until next read)
sram_write  out  1  bridge write pulse
sram_w_addr  out  32  bridge write address
sram_w_data  out  32  bridge write data, low-aligned
sram_w_strb  out  4  bridge strobe: 4'b0001, 4'b0011 or 4'b1111 only

Behaviour:

Reset
- While reset==0, all outputs are 0, including all readies.
- At the reset edge, both FSMs go to IDLE, delay counters clear and latched flags clear.
- A transaction in flight when reset is asserted is dropped: no bridge pulse and no response afterwards.

Read FSM: RD_IDLE -> RD_ISSUE -> RD_DELAY -> RD_RESP -> RD_IDLE
- RD_IDLE: s_arready=1. On arvalid&&arready, latch {araddr[31:2],2'b00} and go to RD_ISSUE.
- RD_ISSUE: sram_read=1 for exactly this one cycle, with sram_r_addr = latched address.
  - Next state is RD_DELAY if R_EXTRA_DELAY>0, else RD_RESP.
- RD_DELAY: down-counter loaded with R_EXTRA_DELAY; go to RD_RESP when it reaches 1.
- RD_RESP: s_rvalid=1, s_rdata = sram_r_data, s_rresp=0.
  - rdata stays stable because no read is issued in this state.
  - On rready, go to RD_IDLE.
- Latency with delay 0: AR handshake in cycle N, sram_read in N+1, rvalid in N+2.
- Back-to-back reads: the next AR is accepted the cycle after the R handshake.

Write FSM: WR_IDLE -> WR_ISSUE -> WR_DELAY -> WR_RESP -> WR_IDLE
- WR_IDLE:
  - s_awready = !aw_got and s_wready = !w_got.
  - AW and W are captured independently in either order or in the same cycle.
  - When both are held (including a same-cycle capture), go to WR_ISSUE.
- Strobe normalisation, with o = byte offset:
  - 0001/0010/0100/1000: byte, o = 0/1/2/3, strb 0001.
  - 0011/1100: half, o = 0/2, strb 0011.
  - 1111: word, o = 0, strb 1111.
  - Outputs: sram_w_addr = {awaddr[31:2], o[1:0]}, sram_w_data = wdata >> (8*o).
  - Any other pattern, including 0000, is unsupported.
- WR_ISSUE: sram_write=1 for exactly one cycle if the strobe is supported; otherwise sram_write stays 0.
  - Next state is WR_DELAY or WR_RESP, as in the read FSM.
- WR_RESP: s_bvalid=1, s_bresp = 2'b00, or 2'b10 if the strobe was unsupported.
  - On bready, go to WR_IDLE and clear aw_got/w_got.
- Latency with delay 0: last of AW/W captured in cycle N, sram_write in N+1, bvalid in N+2.

Concurrency
- The read and write FSMs are fully independent; sram_read and sram_write may be high in the same cycle.
- Same-address collision: the read returns the pre-write data.
- Valid/ready outputs never depend combinationally on the same channel's valid.

Test Plan:
- Reset: hold reset=0 for 3 cycles with arvalid=awvalid=wvalid=1 -> all readies/valids/pulses 0; cycle after release -> arready=awready=wready=1.
- Word read: mem[0x80000004]=0xDEADBEEF, AR 0x80000006 in cycle N -> sram_read=1 with r_addr 0x80000004 in N+1; rvalid, rdata 0xDEADBEEF, rresp 0 in N+2; rready low 3 cycles -> rdata stable.
- Byte write, lane 2: W (wdata 0x00AB0000, wstrb 0100) two cycles before AW 0x80000010 -> one sram_write pulse with w_addr 0x80000012, w_data 0x000000AB, strb 0001; bresp 0.
- Same-cycle AW+W, wstrb 0110 -> no sram_write pulse; bvalid with bresp 2'b10.
- R_EXTRA_DELAY=3, W_EXTRA_DELAY=2, simultaneous read and write to 0x80000020 (old 0x11111111, new word 0x22222222) -> rdata 0x11111111 with rvalid 5 cycles after AR; bvalid 4 cycles after write capture; a following read returns 0x22222222.
- Reset asserted in RD_DELAY -> no rvalid afterwards; a new AR after release completes normally.
